// File: rtl/alu_packet_parser.sv
// Byte-stream command parser: decodes a 4-byte header (opcode, reserved, 16-bit length)
// and packs the payload into little-endian 32-bit words. Malformed packets are drained
// without producing output and are flagged with a single-cycle error pulse.
module alu_packet_parser #(
  parameter int unsigned MAX_LEN = 1024
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [7:0]  opcode_o,
  output logic        pkt_error_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    StHdrOp,
    StHdrRsv,
    StHdrLenL,
    StHdrLenH,
    StPayload,
    StOut,
    StDrain
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        legal_q, legal_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] remaining_q, remaining_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;       // lanes 0..2; lane 3 comes straight from the input byte
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        err_q, err_d;

  logic        accept;
  logic        op_legal;
  logic [15:0] len;
  logic        len_ok;

  assign s_axis_tready = (state_q != StOut);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign op_legal      = (s_axis_tdata >= 8'h10) && (s_axis_tdata <= 8'h15);
  assign len           = {s_axis_tdata, len_lo_q};
  assign len_ok        = (len >= 16'd8) && (len[1:0] == 2'b00) && (32'(len) <= MAX_LEN);

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign opcode_o      = opcode_q;
  assign pkt_error_o   = err_q;
  assign busy_o        = (state_q != StHdrOp);

  // Next-state and datapath decode; everything holds unless a byte or word moves.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    legal_d     = legal_q;
    len_lo_d    = len_lo_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    err_d       = 1'b0;
    unique case (state_q)
      StHdrOp: begin
        if (accept) begin
          opcode_d = s_axis_tdata;
          legal_d  = op_legal;
          state_d  = StHdrRsv;
        end
      end
      StHdrRsv: begin
        if (accept) state_d = StHdrLenL;
      end
      StHdrLenL: begin
        if (accept) begin
          len_lo_d = s_axis_tdata;
          state_d  = StHdrLenH;
        end
      end
      StHdrLenH: begin
        if (accept) begin
          idx_d = 2'd0;
          if (legal_q && len_ok) begin
            remaining_d = len - 16'd4;
            state_d     = StPayload;
          end else begin
            err_d = 1'b1;
            if (len > 16'd4) begin
              remaining_d = len - 16'd4;
              state_d     = StDrain;
            end else begin
              state_d = StHdrOp;
            end
          end
        end
      end
      StPayload: begin
        if (accept) begin
          idx_d       = idx_q + 2'd1;
          remaining_d = remaining_q - 16'd1;
          case (idx_q)
            2'd0:    asm_d[7:0]   = s_axis_tdata;
            2'd1:    asm_d[15:8]  = s_axis_tdata;
            2'd2:    asm_d[23:16] = s_axis_tdata;
            default: begin
              tdata_d  = {s_axis_tdata, asm_q};
              tvalid_d = 1'b1;
              tlast_d  = (remaining_q == 16'd1);
              state_d  = StOut;
            end
          endcase
        end
      end
      StOut: begin
        if (tvalid_q && m_axis_tready) begin
          tvalid_d = 1'b0;
          state_d  = tlast_q ? StHdrOp : StPayload;
        end
      end
      StDrain: begin
        if (accept) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = StHdrOp;
        end
      end
      default: state_d = StHdrOp;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StHdrOp;
      opcode_q    <= 8'h00;
      legal_q     <= 1'b0;
      len_lo_q    <= 8'h00;
      remaining_q <= 16'h0000;
      idx_q       <= 2'd0;
      asm_q       <= 24'h000000;
      tdata_q     <= 32'h00000000;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      legal_q     <= legal_d;
      len_lo_q    <= len_lo_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_packet_parser.sv
// Directed bench for alu_packet_parser: each task drives one scenario and checks inline.
module tb_alu_packet_parser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_tready;
  logic        m_axis_tlast;
  logic [7:0]  opcode_o;
  logic        pkt_error_o;
  logic        busy_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] got_data[$];
  logic        got_last[$];
  int          err_cnt = 0;
  int          acc_cnt = 0;
  int          vld_cnt = 0;
  int          cyc     = 0;

  alu_packet_parser #(.MAX_LEN(1024)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_axis_tlast),
    .opcode_o     (opcode_o),
    .pkt_error_o  (pkt_error_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Passive monitor: records delivered words, error-pulse cycles, accepted bytes.
  always @(posedge clk) begin
    cyc++;
    if (m_axis_tvalid && m_tready) begin
      got_data.push_back(m_axis_tdata);
      got_last.push_back(m_axis_tlast);
    end
    if (m_axis_tvalid) vld_cnt++;
    if (pkt_error_o) err_cnt++;
    if (s_tvalid && s_axis_tready) acc_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      tests++;
      fails++;
      $display("FAIL send_byte: tready stuck low, got %0d cycles required <200", t);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [7:0] ll, input logic [7:0] lh);
    send_byte(op);
    send_byte(8'h00);
    send_byte(ll);
    send_byte(lh);
  endtask

  task automatic send_payload(input int n, input logic [7:0] start);
    logic [7:0] b;
    b = start;
    for (int i = 0; i < n; i++) begin
      send_byte(b);
      b = b + 8'd1;
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (m_axis_tvalid !== 1'b0) begin fails++;
      $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid); end
    tests++; if (m_axis_tlast !== 1'b0) begin fails++;
      $display("FAIL rst_tlast: got %b required 0", m_axis_tlast); end
    tests++; if (m_axis_tdata !== 32'h0) begin fails++;
      $display("FAIL rst_tdata: got %h required 0", m_axis_tdata); end
    tests++; if (opcode_o !== 8'h00) begin fails++;
      $display("FAIL rst_opcode: got %h required 00", opcode_o); end
    tests++; if (pkt_error_o !== 1'b0) begin fails++;
      $display("FAIL rst_err: got %b required 0", pkt_error_o); end
    tests++; if (busy_o !== 1'b0) begin fails++;
      $display("FAIL rst_busy: got %b required 0", busy_o); end
    tests++; if (s_axis_tready !== 1'b1) begin fails++;
      $display("FAIL rst_tready: got %b required 1", s_axis_tready); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_valid_add();
    int e0;
    e0 = err_cnt;
    got_data.delete();
    got_last.delete();
    send_hdr(8'h10, 8'h0C, 8'h00);
    tests++; if (busy_o !== 1'b1) begin fails++;
      $display("FAIL add_busy: got %b required 1", busy_o); end
    send_payload(4, 8'h01);
    tests++; if (m_axis_tvalid !== 1'b1) begin fails++;
      $display("FAIL add_latency: tvalid got %b required 1", m_axis_tvalid); end
    tests++; if (m_axis_tdata !== 32'h04030201) begin fails++;
      $display("FAIL add_word0_now: got %h required 04030201", m_axis_tdata); end
    send_payload(4, 8'h05);
    settle();
    tests++; if (got_data.size() !== 2) begin fails++;
      $display("FAIL add_count: got %0d required 2", got_data.size()); end
    if (got_data.size() == 2) begin
      tests++; if (got_data[0] !== 32'h04030201 || got_last[0] !== 1'b0) begin fails++;
        $display("FAIL add_w0: got %h/%b required 04030201/0", got_data[0], got_last[0]); end
      tests++; if (got_data[1] !== 32'h08070605 || got_last[1] !== 1'b1) begin fails++;
        $display("FAIL add_w1: got %h/%b required 08070605/1", got_data[1], got_last[1]); end
    end
    tests++; if (opcode_o !== 8'h10) begin fails++;
      $display("FAIL add_opcode: got %h required 10", opcode_o); end
    tests++; if (err_cnt !== e0) begin fails++;
      $display("FAIL add_noerr: got %0d pulses required 0", err_cnt - e0); end
    tests++; if (busy_o !== 1'b0) begin fails++;
      $display("FAIL add_idle: busy got %b required 0", busy_o); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w[2];
    exp_w[0] = 32'h24232221;
    exp_w[1] = 32'h28272625;
    got_data.delete();
    got_last.delete();
    m_tready = 1'b0;
    fork
      begin
        send_hdr(8'h12, 8'h0C, 8'h00);
        send_payload(8, 8'h21);
      end
      begin
        for (int w = 0; w < 2; w++) begin
          int t = 0;
          logic [31:0] hd;
          logic        hl;
          @(negedge clk);
          while (!m_axis_tvalid && t < 100) begin
            @(negedge clk);
            t++;
          end
          tests++; if (m_axis_tvalid !== 1'b1) begin fails++;
            $display("FAIL bp_wait%0d: tvalid got %b required 1", w, m_axis_tvalid); end
          hd = m_axis_tdata;
          hl = m_axis_tlast;
          tests++; if (hd !== exp_w[w]) begin fails++;
            $display("FAIL bp_word%0d: got %h required %h", w, hd, exp_w[w]); end
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (m_axis_tdata !== hd || m_axis_tlast !== hl || m_axis_tvalid !== 1'b1 ||
                s_axis_tready !== 1'b0) begin
              fails++;
              $display("FAIL bp_hold%0d: got %h/%b/v%b/r%b required %h/%b/v1/r0", w,
                       m_axis_tdata, m_axis_tlast, m_axis_tvalid, s_axis_tready, hd, hl);
            end
          end
          m_tready = 1'b1;
          @(posedge clk);
          #1;
          m_tready = 1'b0;
        end
      end
    join
    m_tready = 1'b1;
    settle();
    tests++; if (got_data.size() !== 2) begin fails++;
      $display("FAIL bp_count: got %0d required 2", got_data.size()); end
    if (got_data.size() == 2) begin
      tests++; if (got_data[0] !== exp_w[0] || got_last[0] !== 1'b0 ||
                   got_data[1] !== exp_w[1] || got_last[1] !== 1'b1) begin fails++;
        $display("FAIL bp_order: got %h/%b %h/%b required %h/0 %h/1", got_data[0], got_last[0],
                 got_data[1], got_last[1], exp_w[0], exp_w[1]); end
    end
  endtask

  task automatic test_illegal_opcode();
    int e0, a0, v0;
    e0 = err_cnt;
    a0 = acc_cnt;
    v0 = vld_cnt;
    got_data.delete();
    got_last.delete();
    send_hdr(8'h7F, 8'h0C, 8'h00);
    tests++; if (pkt_error_o !== 1'b1) begin fails++;
      $display("FAIL ill_pulse: got %b required 1", pkt_error_o); end
    tests++; if (opcode_o !== 8'h7F) begin fails++;
      $display("FAIL ill_opcode: got %h required 7f", opcode_o); end
    send_payload(8, 8'h01);
    tests++; if (busy_o !== 1'b0) begin fails++;
      $display("FAIL ill_drained: busy got %b required 0", busy_o); end
    settle();
    tests++; if (err_cnt - e0 !== 1) begin fails++;
      $display("FAIL ill_errcnt: got %0d required 1", err_cnt - e0); end
    tests++; if (acc_cnt - a0 !== 12) begin fails++;
      $display("FAIL ill_consumed: got %0d required 12", acc_cnt - a0); end
    tests++; if (vld_cnt !== v0 || got_data.size() !== 0) begin fails++;
      $display("FAIL ill_nooutput: got %0d valid cycles required 0", vld_cnt - v0); end
    send_hdr(8'h13, 8'h0C, 8'h00);
    send_payload(8, 8'h31);
    settle();
    tests++; if (got_data.size() !== 2) begin fails++;
      $display("FAIL ill_next_count: got %0d required 2", got_data.size()); end
    if (got_data.size() == 2) begin
      tests++; if (got_data[0] !== 32'h34333231 || got_data[1] !== 32'h38373635 ||
                   got_last[1] !== 1'b1) begin fails++;
        $display("FAIL ill_next_words: got %h %h/%b required 34333231 38373635/1",
                 got_data[0], got_data[1], got_last[1]); end
    end
  endtask

  task automatic test_bad_length();
    int e0, v0;
    e0 = err_cnt;
    v0 = vld_cnt;
    // LEN=10: legal opcode but not word-aligned, 6 bytes to drain
    send_hdr(8'h10, 8'h0A, 8'h00);
    tests++; if (pkt_error_o !== 1'b1 || busy_o !== 1'b1) begin fails++;
      $display("FAIL len10_hdr: err/busy got %b/%b required 1/1", pkt_error_o, busy_o); end
    send_payload(5, 8'hA0);
    tests++; if (busy_o !== 1'b1 || pkt_error_o !== 1'b0) begin fails++;
      $display("FAIL len10_mid: busy/err got %b/%b required 1/0", busy_o, pkt_error_o); end
    send_payload(1, 8'hA5);
    tests++; if (busy_o !== 1'b0) begin fails++;
      $display("FAIL len10_end: busy got %b required 0", busy_o); end
    // LEN=4: nothing to drain
    send_hdr(8'h10, 8'h04, 8'h00);
    tests++; if (pkt_error_o !== 1'b1 || busy_o !== 1'b0) begin fails++;
      $display("FAIL len4: err/busy got %b/%b required 1/0", pkt_error_o, busy_o); end
    // LEN=0x0404 exceeds MAX_LEN: 1024 bytes to drain
    send_hdr(8'h10, 8'h04, 8'h04);
    tests++; if (pkt_error_o !== 1'b1 || busy_o !== 1'b1) begin fails++;
      $display("FAIL len1028_hdr: err/busy got %b/%b required 1/1", pkt_error_o, busy_o); end
    send_payload(1023, 8'h00);
    tests++; if (busy_o !== 1'b1) begin fails++;
      $display("FAIL len1028_mid: busy got %b required 1", busy_o); end
    send_payload(1, 8'hFF);
    tests++; if (busy_o !== 1'b0) begin fails++;
      $display("FAIL len1028_end: busy got %b required 0", busy_o); end
    settle();
    tests++; if (err_cnt - e0 !== 3) begin fails++;
      $display("FAIL badlen_errcnt: got %0d required 3", err_cnt - e0); end
    tests++; if (vld_cnt !== v0) begin fails++;
      $display("FAIL badlen_nooutput: got %0d valid cycles required 0", vld_cnt - v0); end
  endtask

  task automatic test_reset_mid();
    send_hdr(8'h14, 8'h0C, 8'h00);
    send_payload(2, 8'h41);
    reset_n = 1'b0;
    #2;
    tests++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'h0 ||
        opcode_o !== 8'h00 || pkt_error_o !== 1'b0 || busy_o !== 1'b0 ||
        s_axis_tready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_vals: got v%b l%b d%h op%h e%b b%b r%b required v0 l0 d0 op00 e0 b0 r1",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, opcode_o, pkt_error_o, busy_o,
               s_axis_tready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    got_data.delete();
    got_last.delete();
    send_hdr(8'h15, 8'h0C, 8'h00);
    send_payload(8, 8'h51);
    settle();
    tests++; if (got_data.size() !== 2) begin fails++;
      $display("FAIL midrst_count: got %0d required 2", got_data.size()); end
    if (got_data.size() == 2) begin
      tests++; if (got_data[0] !== 32'h54535251 || got_data[1] !== 32'h58575655) begin fails++;
        $display("FAIL midrst_words: got %h %h required 54535251 58575655",
                 got_data[0], got_data[1]); end
    end
    tests++; if (opcode_o !== 8'h15) begin fails++;
      $display("FAIL midrst_opcode: got %h required 15", opcode_o); end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [31:0] exp_w[4];
    logic        exp_l[4];
    exp_w[0] = 32'h64636261; exp_l[0] = 1'b0;
    exp_w[1] = 32'h68676665; exp_l[1] = 1'b1;
    exp_w[2] = 32'h74737271; exp_l[2] = 1'b0;
    exp_w[3] = 32'h78777675; exp_l[3] = 1'b1;
    got_data.delete();
    got_last.delete();
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    send_hdr(8'h11, 8'h0C, 8'h00);
    send_payload(8, 8'h61);
    tests++; if (opcode_o !== 8'h11) begin fails++;
      $display("FAIL b2b_opA: got %h required 11", opcode_o); end
    send_byte(8'h15);
    tests++; if (opcode_o !== 8'h15) begin fails++;
      $display("FAIL b2b_opB: got %h required 15", opcode_o); end
    send_byte(8'h00);
    send_byte(8'h0C);
    send_byte(8'h00);
    send_payload(8, 8'h71);
    // 24 bytes plus three OUT cycles before the last acceptance
    tests++; if (cyc - c0 !== 27) begin fails++;
      $display("FAIL b2b_cycles: got %0d required 27", cyc - c0); end
    settle();
    tests++; if (got_data.size() !== 4) begin fails++;
      $display("FAIL b2b_count: got %0d required 4", got_data.size()); end
    if (got_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (got_data[i] !== exp_w[i] || got_last[i] !== exp_l[i]) begin fails++;
          $display("FAIL b2b_w%0d: got %h/%b required %h/%b", i, got_data[i], got_last[i],
                   exp_w[i], exp_l[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_add();
    test_backpressure();
    test_illegal_opcode();
    test_bad_length();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
